cache_refill_ctrl: RTL

- Miss-refill controller directly downstream of cache_direct_mapped's hit/miss decision.
- Accepts one miss (physical address) at a time and fetches the full line from main memory over a req/ack word interface.
- Writes each returned word into the cache data array, then writes tag and valid bit to complete the fill.
- Pure sequential FSM plus beat counter. Handles no hits and does no data muxing.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/refill_beat_ctr.sv | 38 +++
 rtl/cache_refill_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache constants and types, used by cache_direct_mapped and the
// miss-refill controller. The address is split as {tag, index, word, byte}.
package cache_pkg;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 8;
    localparam int BYTE_W   = 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W - BYTE_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        COMMIT = 2'd2
    } refill_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] word;
        logic [BYTE_W-1:0]   byte_sel;
    } addr_fields_t;

    // Split a physical address into its cache fields.
    function automatic addr_fields_t decode_addr(input logic [ADDR_W-1:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/refill_beat_ctr.sv
// Beat counter for a line refill: word pointer that wraps around the line,
// number of beats already returned, and a flag marking the final beat.
module refill_beat_ctr #(
    parameter int CTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CTR_W-1:0] start_word_i,
    input  logic             advance_i,
    output logic [CTR_W-1:0] word_o,
    output logic [CTR_W-1:0] beat_o,
    output logic             last_o
);

    logic [CTR_W-1:0] word_reg;
    logic [CTR_W-1:0] beat_reg;

    // Load the start word on accept; step word and beat on each returned beat.
    // Both wrap naturally at the line size.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_reg <= '0;
            beat_reg <= '0;
        end else if (load_i) begin
            word_reg <= start_word_i;
            beat_reg <= '0;
        end else if (advance_i) begin
            word_reg <= word_reg + 1'b1;
            beat_reg <= beat_reg + 1'b1;
        end
    end

    assign word_o = word_reg;
    assign beat_o = beat_reg;
    assign last_o = &beat_reg;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller: accepts one missing address, fetches the whole line
// over a req/ack word interface, writes every word into the data array and
// finally writes tag/valid. Build option CACHE_REFILL_CWF_EN enables critical
// word first ordering plus the crit_valid_o/crit_data_o early-restart outputs.
module cache_refill_ctrl
    import cache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                miss_valid_i,
    input  logic [ADDR_W-1:0]   miss_addr_i,
    output logic                miss_ready_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                fill_we_o,
    output logic [INDEX_W-1:0]  fill_index_o,
    output logic [OFFSET_W-1:0] fill_word_o,
    output logic [DATA_W-1:0]   fill_data_o,
    output logic                fill_tag_we_o,
    output logic [TAG_W-1:0]    fill_tag_o,
    output logic                fill_done_o
`ifdef CACHE_REFILL_CWF_EN
    ,
    output logic                crit_valid_o,
    output logic [DATA_W-1:0]   crit_data_o
`endif
);

    refill_state_t       state_reg;
    refill_state_t       state_next;
    addr_fields_t        miss_fields;
    logic [TAG_W-1:0]    tag_reg;
    logic [INDEX_W-1:0]  index_reg;
    logic [OFFSET_W-1:0] start_word;
    logic [OFFSET_W-1:0] word_ptr;
    logic [OFFSET_W-1:0] beat_cnt;
    logic                last_beat;
    logic                accept;
    logic                beat_ack;
    logic                fill_we_reg;
    logic [OFFSET_W-1:0] fill_word_reg;
    logic [DATA_W-1:0]   fill_data_reg;
    logic                addr_unused;

    assign miss_fields = decode_addr(miss_addr_i);
    assign accept      = miss_valid_i & miss_ready_o;
    // Acks only count while a request is outstanding; strays are dropped.
    assign beat_ack    = mem_req_o & mem_ack_i;

`ifdef CACHE_REFILL_CWF_EN
    assign start_word  = miss_fields.word;
    assign addr_unused = ^miss_fields.byte_sel;
`else
    assign start_word  = '0;
    assign addr_unused = ^{miss_fields.word, miss_fields.byte_sel, beat_cnt};
`endif

    refill_beat_ctr #(
        .CTR_W(OFFSET_W)
    ) u_beat_ctr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .start_word_i(start_word),
        .advance_i   (beat_ack),
        .word_o      (word_ptr),
        .beat_o      (beat_cnt),
        .last_o      (last_beat)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and the state-decoded handshake/commit strobes.
    always_comb begin
        state_next    = state_reg;
        miss_ready_o  = 1'b0;
        mem_req_o     = 1'b0;
        fill_tag_we_o = 1'b0;
        fill_done_o   = 1'b0;
        case (state_reg)
            IDLE: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i && last_beat) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                fill_tag_we_o = 1'b1;
                fill_done_o   = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture tag and index of the accepted miss; they stay put for the fill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_reg   <= '0;
            index_reg <= '0;
        end else if (accept) begin
            tag_reg   <= miss_fields.tag;
            index_reg <= miss_fields.index;
        end
    end

    // Register each returned word with its position; the write strobe
    // follows the ack by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_we_reg   <= 1'b0;
            fill_word_reg <= '0;
            fill_data_reg <= '0;
        end else begin
            fill_we_reg <= beat_ack;
            if (beat_ack) begin
                fill_word_reg <= word_ptr;
                fill_data_reg <= mem_rdata_i;
            end
        end
    end

`ifdef CACHE_REFILL_CWF_EN
    logic              crit_valid_reg;
    logic [DATA_W-1:0] crit_data_reg;

    // The first beat is the requested word: expose it once for early restart.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            crit_valid_reg <= 1'b0;
            crit_data_reg  <= '0;
        end else begin
            crit_valid_reg <= beat_ack && (beat_cnt == '0);
            if (beat_ack && (beat_cnt == '0)) begin
                crit_data_reg <= mem_rdata_i;
            end
        end
    end

    assign crit_valid_o = crit_valid_reg;
    assign crit_data_o  = crit_data_reg;
`endif

    assign mem_addr_o   = {tag_reg, index_reg, word_ptr, {BYTE_W{1'b0}}};
    assign fill_index_o = index_reg;
    assign fill_tag_o   = tag_reg;
    assign fill_we_o    = fill_we_reg;
    assign fill_word_o  = fill_word_reg;
    assign fill_data_o  = fill_data_reg;

endmodule
